// File: rtl/int_sched.sv
// Interrupt scheduler: edge-captured pending bits, mask/global enable, fixed lowest-index priority, EXL tracking until eret.
// Optional macro INT_SYNC_EN inserts a two-flop synchroniser on irq_in ahead of the edge detector.
module int_sched #(
    parameter int NUM_IRQ = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               ie_we,
    input  logic               ie_wdata,
    input  logic [NUM_IRQ-1:0] pend_clr,
    input  logic               exc_req,
    input  logic               slot_valid,
    input  logic               eret,
    output logic               int_req,
    output logic [2:0]         int_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               exl
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_IRQ-1:0] w_irq;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_ie;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [2:0]         w_prio_id;
    logic [2:0]         r_int_id;
    logic               w_id_we;
    logic [2:0]         w_id_val;

`ifdef INT_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq = r_sync2;
`else
    assign w_irq = irq_in;
`endif

    // A new rising edge beats a same-cycle software clear so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_ie       <= 1'b0;
        end else begin
            r_irq_prev <= w_irq;
            r_pending  <= (r_pending & ~pend_clr) | (w_irq & ~r_irq_prev);
            if (mask_we) r_mask <= mask_wdata;
            if (ie_we)   r_ie   <= ie_wdata;
        end
    end

    assign w_eligible = r_pending & r_mask & {NUM_IRQ{r_ie}};

    always_comb begin
        w_prio_id = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) w_prio_id = 3'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        int_req     = 1'b0;
        w_id_we     = 1'b0;
        w_id_val    = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (exc_req) begin
                    w_state_nxt = S_SERVICE;
                    w_id_we     = 1'b1;
                end else if (|w_eligible) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                // A synchronous exception pre-empts the interrupt; the latched id reads 0.
                if (exc_req) begin
                    w_state_nxt = S_SERVICE;
                    w_id_we     = 1'b1;
                end else if (slot_valid) begin
                    int_req     = 1'b1;
                    w_state_nxt = S_SERVICE;
                    w_id_we     = 1'b1;
                    w_id_val    = w_prio_id;
                end else if (w_eligible == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (eret) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_int_id <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_id_we) r_int_id <= w_id_val;
        end
    end

    always_comb begin
        int_id = 3'd0;
        if (r_state == S_ARM)          int_id = w_prio_id;
        else if (r_state == S_SERVICE) int_id = r_int_id;
    end

    assign pending = r_pending;
    assign exl     = (r_state == S_SERVICE);

endmodule

// File: tb/tb_int_sched.sv
// Directed scenarios plus randomized traffic for int_sched, checked against a cycle-level behavioural model.
module tb_int_sched;
    localparam int N = 6;
`ifdef INT_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic         clk, rst;
    logic [N-1:0] irq_in, mask_wdata, pend_clr, pending;
    logic         mask_we, ie_we, ie_wdata, exc_req, slot_valid, eret;
    logic         int_req, exl;
    logic [2:0]   int_id;

    int tests = 0;
    int fails = 0;

    // Behavioural model: mode flags rather than an encoded state.
    logic [N-1:0] m_pend, m_prev, m_mask, m_s1, m_s2;
    logic         m_ie, m_armed, m_svc;
    logic [2:0]   m_id;

    int_sched #(.NUM_IRQ(N)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .ie_we(ie_we), .ie_wdata(ie_wdata), .pend_clr(pend_clr),
        .exc_req(exc_req), .slot_valid(slot_valid), .eret(eret),
        .int_req(int_req), .int_id(int_id), .pending(pending), .exl(exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mask = '0; m_s1 = '0; m_s2 = '0;
        m_ie = 1'b0; m_armed = 1'b0; m_svc = 1'b0; m_id = 3'd0;
    endtask

    // Check outputs at the falling edge, advance the model, then return just after the rising edge.
    task automatic tick();
        logic [N-1:0] elig, line;
        @(negedge clk);
        if (rst) model_reset();
        elig = m_pend & m_mask & {N{m_ie}};
        chk("m_req",  8'(int_req), 8'(m_armed && slot_valid && !exc_req));
        chk("m_id",   8'(int_id),  8'(m_armed ? lowest(elig) : (m_svc ? m_id : 3'd0)));
        chk("m_exl",  8'(exl),     8'(m_svc));
        chk("m_pend", 8'(pending), 8'(m_pend));
        if (!rst) begin
            line   = (L == 2) ? m_s2 : irq_in;
            m_pend = (m_pend & ~pend_clr) | (line & ~m_prev);
            m_prev = line;
            m_s2   = m_s1;
            m_s1   = irq_in;
            if (m_svc) begin
                if (eret) m_svc = 1'b0;
            end else if (exc_req) begin
                m_armed = 1'b0; m_svc = 1'b1; m_id = 3'd0;
            end else if (m_armed) begin
                if (slot_valid) begin
                    m_armed = 1'b0; m_svc = 1'b1; m_id = lowest(elig);
                end else if (elig == '0) begin
                    m_armed = 1'b0;
                end
            end else if (elig != '0) begin
                m_armed = 1'b1;
            end
            if (mask_we) m_mask = mask_wdata;
            if (ie_we)   m_ie   = ie_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ie_we = 1'b0; ie_wdata = 1'b0;
        pend_clr = '0; exc_req = 1'b0; slot_valid = 1'b0; eret = 1'b0;
        model_reset();
        #2;
        chk("rst_req", 8'(int_req), 8'h00);
        chk("rst_id",  8'(int_id),  8'h00);
        chk("rst_pend", 8'(pending), 8'h00);
        chk("rst_exl", 8'(exl), 8'h00);
        tick();
        rst = 1'b0;

        // Scenario 1: single source, slot ready
        mask_we = 1'b1; mask_wdata = 6'h3F; ie_we = 1'b1; ie_wdata = 1'b1;
        tick();
        mask_we = 1'b0; ie_we = 1'b0;
        irq_in = 6'h04; slot_valid = 1'b1;
        tick();
        repeat (L) tick();
        #1 chk("s1_pend", 8'(pending), 8'h04);
        tick();
        #1 chk("s1_req", 8'(int_req), 8'h01);
        chk("s1_id", 8'(int_id), 8'h02);
        chk("s1_exl0", 8'(exl), 8'h00);
        tick();
        #1 chk("s1_exl1", 8'(exl), 8'h01);
        chk("s1_noreq", 8'(int_req), 8'h00);
        slot_valid = 1'b0; eret = 1'b1;
        tick();
        eret = 1'b0; irq_in = '0; pend_clr = 6'h3F;
        tick();
        pend_clr = '0;
        tick(); tick();

        // Scenario 2: two sources, slot held off
        irq_in = 6'h12;
        repeat (2 + L) tick();
        for (int k = 0; k < 3; k++) begin
            #1 chk("s2_hold", 8'(int_req), 8'h00);
            chk("s2_armid", 8'(int_id), 8'h01);
            tick();
        end
        slot_valid = 1'b1;
        #1 chk("s2_req", 8'(int_req), 8'h01);
        chk("s2_id", 8'(int_id), 8'h01);
        chk("s2_pend", 8'(pending), 8'h12);
        tick();
        slot_valid = 1'b0;
        #1 chk("s2_latid", 8'(int_id), 8'h01);
        eret = 1'b1;
        tick();
        eret = 1'b0; irq_in = '0; pend_clr = 6'h3F;
        tick();
        pend_clr = '0;
        tick(); tick();

        // Scenario 3: exception pre-empts an armed interrupt
        irq_in = 6'h08;
        repeat (2 + L) tick();
        exc_req = 1'b1; slot_valid = 1'b1;
        #1 chk("s3_noreq", 8'(int_req), 8'h00);
        tick();
        exc_req = 1'b0; slot_valid = 1'b0;
        #1 chk("s3_exl", 8'(exl), 8'h01);
        chk("s3_id0", 8'(int_id), 8'h00);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        #1 chk("s3_idle", 8'(exl), 8'h00);
        chk("s3_idleid", 8'(int_id), 8'h00);
        tick();
        #1 chk("s3_rearm", 8'(int_id), 8'h03);

`ifndef INT_SYNC_EN
        // Scenario 4: clear and new edge in the same cycle
        irq_in = '0; pend_clr = 6'h3F;
        tick();
        pend_clr = '0;
        tick(); tick();
        irq_in = 6'h04;
        tick();
        irq_in = '0;
        tick();
        irq_in = 6'h04; pend_clr = 6'h04;
        #1 chk("s4_arm", 8'(int_id), 8'h02);
        tick();
        pend_clr = '0;
        #1 chk("s4_pend", 8'(pending), 8'h04);
        chk("s4_still", 8'(int_id), 8'h02);

        // Scenario 5: global enable drop and restore
        ie_we = 1'b1; ie_wdata = 1'b0;
        tick();
        ie_we = 1'b0;
        #1 chk("s5_armoff", 8'(int_id), 8'h00);
        tick();
        ie_we = 1'b1; ie_wdata = 1'b1;
        tick();
        ie_we = 1'b0;
        tick();
        #1 chk("s5_rearm", 8'(int_id), 8'h02);
`endif

        // Reset mid-operation with a line held high through release
        irq_in = 6'h04; slot_valid = 1'b1; rst = 1'b1;
        #1 chk("mr_req", 8'(int_req), 8'h00);
        chk("mr_exl", 8'(exl), 8'h00);
        chk("mr_pend", 8'(pending), 8'h00);
        tick();
        rst = 1'b0;
        repeat (1 + L) tick();
        #1 chk("mr_edge", 8'(pending), 8'h04);
        slot_valid = 1'b0;
        mask_we = 1'b1; mask_wdata = 6'h3F; ie_we = 1'b1; ie_wdata = 1'b1;
        tick();

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            rst        = ($urandom_range(0, 199) == 0);
            irq_in     = irq_in ^ N'($urandom & $urandom & $urandom);
            mask_we    = ($urandom_range(0, 29) == 0);
            mask_wdata = N'($urandom);
            ie_we      = ($urandom_range(0, 29) == 0);
            ie_wdata   = ($urandom_range(0, 3) != 0);
            pend_clr   = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            exc_req    = ($urandom_range(0, 19) == 0);
            eret       = ($urandom_range(0, 7) == 0);
            slot_valid = 1'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
